// File: rtl/pipe_pkg.sv
// Shared types for the MEM/WB writeback boundary.
// Default payload geometry, state encoding and the hard-wired zero register.
package pipe_pkg;

  localparam int WB_DATA_W     = 32;
  localparam int WB_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic                     mem_to_reg;
    logic                     reg_write;
    logic [WB_REG_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0]     alu_result;
    logic [WB_DATA_W-1:0]     read_data;
  } wb_payload_t;

  localparam logic [WB_REG_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/pipe_slot.sv
// One payload register of the MEM/WB skid buffer.
// Load-enabled, cleared to zero by synchronous reset.
module pipe_slot #(
  parameter int W = 74
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/mem_wb_skid_reg.sv
// MEM/WB pipeline register with valid/ready, 2-entry skid and flush.
// Main slot drives out_*; skid slot catches the entry in flight on a stall.
module mem_wb_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W            = 32,
  parameter int REG_ADDR_W        = 5,
  parameter bit ZERO_REG_SUPPRESS = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mem_to_reg,
  input  logic                  in_reg_write,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_mem_to_reg,
  output logic                  out_reg_write,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [DATA_W-1:0]     out_alu_result,
  output logic [DATA_W-1:0]     out_read_data,
  output logic [DATA_W-1:0]     out_wb_data,
  output logic                  out_wb_en,
  output logic [1:0]            occupancy
);

  localparam int PW = 2 + REG_ADDR_W + 2 * DATA_W;

  wb_state_e     state;
  wb_state_e     state_nxt;
  logic [PW-1:0] in_vec;
  logic [PW-1:0] main_d;
  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;
  logic          main_ld;
  logic          skid_ld;
  logic          rd_zero;

  assign in_vec = {in_mem_to_reg, in_reg_write, in_rd,
                   in_alu_result, in_read_data};

  assign {out_mem_to_reg, out_reg_write, out_rd,
          out_alu_result, out_read_data} = main_q;

  always_ff @(posedge clk) begin
    if (reset)
      state <= EMPTY;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (in_valid) state_nxt = ONE;
        ONE: begin
          if (in_valid && !out_ready)
            state_nxt = FULL;
          else if (!in_valid && out_ready)
            state_nxt = EMPTY;
        end
        FULL: if (out_ready) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Loads are gated by flush so a squashed cycle never disturbs payload.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occupancy = 2'd0;
    main_ld   = 1'b0;
    skid_ld   = 1'b0;
    main_d    = in_vec;
    unique case (state)
      EMPTY: begin
        main_ld = in_valid && !flush;
      end
      ONE: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
        main_ld   = in_valid && out_ready && !flush;
        skid_ld   = in_valid && !out_ready && !flush;
      end
      FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
        main_ld   = out_ready && !flush;
        main_d    = skid_q;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  pipe_slot #(.W(PW)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_ld),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_slot #(.W(PW)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_ld),
    .d     (in_vec),
    .q     (skid_q)
  );

  assign out_wb_data = out_mem_to_reg ? out_read_data : out_alu_result;

  assign rd_zero = ZERO_REG_SUPPRESS &&
                   (out_rd == REG_ADDR_W'(REG_ZERO));

  assign out_wb_en = out_valid && out_ready &&
                     out_reg_write && !rd_zero;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Self-checking bench for mem_wb_skid_reg against a queue-based model.
// Directed scenarios followed by a randomized handshake run.
module tb_mem_wb_skid_reg;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_mem_to_reg, in_reg_write;
  logic [4:0]  in_rd;
  logic [31:0] in_alu_result, in_read_data;

  logic        in_ready, out_valid, out_mem_to_reg, out_reg_write;
  logic [4:0]  out_rd;
  logic [31:0] out_alu_result, out_read_data, out_wb_data;
  logic        out_wb_en;
  logic [1:0]  occupancy;

  logic        in_ready1, out_valid1, out_m2r1, out_rw1;
  logic [4:0]  out_rd1;
  logic [31:0] out_alu1, out_rdat1, out_wbd1;
  logic        out_wb_en1;
  logic [1:0]  occ1;

  int ncmp = 0;
  int nerr = 0;

  wb_payload_t q[$];
  bit          fresh;

  always #5 clk = ~clk;

  mem_wb_skid_reg dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
    .in_rd(in_rd), .in_alu_result(in_alu_result),
    .in_read_data(in_read_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write),
    .out_rd(out_rd), .out_alu_result(out_alu_result),
    .out_read_data(out_read_data), .out_wb_data(out_wb_data),
    .out_wb_en(out_wb_en), .occupancy(occupancy)
  );

  mem_wb_skid_reg #(.ZERO_REG_SUPPRESS(1'b0)) dut_nz (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
    .in_rd(in_rd), .in_alu_result(in_alu_result),
    .in_read_data(in_read_data),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_mem_to_reg(out_m2r1), .out_reg_write(out_rw1),
    .out_rd(out_rd1), .out_alu_result(out_alu1),
    .out_read_data(out_rdat1), .out_wb_data(out_wbd1),
    .out_wb_en(out_wb_en1), .occupancy(occ1)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit v, bit m2r, bit rw, logic [4:0] rd,
                       logic [31:0] alu, logic [31:0] rdat,
                       bit ordy, bit fl, bit rst);
    in_valid      = v;
    in_mem_to_reg = m2r;
    in_reg_write  = rw;
    in_rd         = rd;
    in_alu_result = alu;
    in_read_data  = rdat;
    out_ready     = ordy;
    flush         = fl;
    reset         = rst;
  endtask

  // Compare outputs to the model, then advance the model across the edge.
  task automatic step();
    wb_payload_t h;
    bit vld, acc, con;
    @(negedge clk);
    vld = q.size() > 0;
    h   = vld ? q[0] : '0;
    chk("out_valid", 32'(out_valid), 32'(vld));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    chk("wb_en", 32'(out_wb_en),
        32'(vld && out_ready && h.reg_write && h.rd != 0));
    chk("wb_en_nz", 32'(out_wb_en1),
        32'(vld && out_ready && h.reg_write));
    if (vld || fresh) begin
      chk("rd", 32'(out_rd), 32'(h.rd));
      chk("reg_write", 32'(out_reg_write), 32'(h.reg_write));
      chk("mem_to_reg", 32'(out_mem_to_reg), 32'(h.mem_to_reg));
      chk("alu", out_alu_result, h.alu_result);
      chk("rdata", out_read_data, h.read_data);
      chk("wb_data", out_wb_data,
          h.mem_to_reg ? h.read_data : h.alu_result);
    end
    acc = in_valid && q.size() < 2;
    con = vld && out_ready;
    @(posedge clk);
    if (reset) begin
      q.delete();
      fresh = 1'b1;
    end else if (flush) begin
      q.delete();
    end else begin
      if (con) void'(q.pop_front());
      if (acc) begin
        q.push_back('{in_mem_to_reg, in_reg_write, in_rd,
                      in_alu_result, in_read_data});
        fresh = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    fresh = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
    step();
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step();

    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 5'(3 + i), 32'h10 + 32'(i), 32'hBEEF, 1, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step();

    drive(1, 1, 1, 5'd7, 32'h111, 32'hDEAD, 0, 0, 0);
    step();
    drive(1, 0, 1, 5'd8, 32'h222, 32'h0, 0, 0, 0);
    step();
    drive(1, 0, 1, 5'd9, 32'h333, 32'h0, 0, 0, 0);
    step();
    step();
    chk("bp_occ", 32'(occupancy), 32'd2);
    chk("bp_hold", out_wb_data, 32'hDEAD);
    drive(1, 0, 1, 5'd9, 32'h333, 32'h0, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step();
    step();
    step();

    drive(1, 0, 1, 5'd0, 32'h55, 32'h0, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step();
    chk("r0_empty", 32'(out_valid), 32'd0);

    drive(1, 0, 1, 5'd1, 32'hA1, 32'h0, 0, 0, 0);
    step();
    drive(1, 0, 1, 5'd2, 32'hA2, 32'h0, 0, 0, 0);
    step();
    drive(1, 0, 1, 5'd3, 32'hA3, 32'h0, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step();
    step();

    drive(1, 0, 1, 5'd4, 32'hB1, 32'h0, 1, 0, 0);
    step();
    drive(1, 0, 1, 5'd5, 32'hB2, 32'h0, 1, 1, 1);
    step();
    drive(1, 1, 1, 5'd6, 32'hB3, 32'hC3, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    step();
    step();

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
            5'($urandom_range(0, 3)), $urandom, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0,
            $urandom_range(0, 80) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
